// File: rtl/level_from_edges.sv
// Edge-to-level encoder: turns one-cycle rise/fall strobes into a level
// waveform with enforced minimum high/low times and a one-deep pending slot.
module level_from_edges #(
   parameter int MIN_HIGH = 4,
   parameter int MIN_LOW  = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic rise_req,
   input  logic fall_req,
   output logic level_out,
   output logic rise_done,
   output logic fall_done,
   output logic dropped,
   output logic busy
);

   localparam int          HIGH_C    = (MIN_HIGH < 1) ? 1 : MIN_HIGH;
   localparam int          LOW_C     = (MIN_LOW  < 1) ? 1 : MIN_LOW;
   localparam logic [15:0] HIGH_LOAD = 16'(HIGH_C - 1);
   localparam logic [15:0] LOW_LOAD  = 16'(LOW_C - 1);

   logic        level_q, level_d;
   logic [15:0] hold_q, hold_d;
   logic        pend_q, pend_d;
   logic        rise_done_q, rise_done_d;
   logic        fall_done_q, fall_done_d;
   logic        dropped_q, dropped_d;

   logic opp_req, same_req, hold_zero, cancel, accept, drop_opp;

   // Requests are classified relative to the current level, not by name.
   assign opp_req   = level_q ? fall_req : rise_req;
   assign same_req  = level_q ? rise_req : fall_req;
   assign hold_zero = (hold_q == 16'd0);
   // A same-level strobe only cancels when it arrives alone.
   assign cancel    = same_req & ~opp_req & pend_q;
   assign accept    = hold_zero & (opp_req | (pend_q & ~cancel));

   always_comb begin
      // NOTE: every comb output gets a default first so no latch is inferred.
      level_d     = level_q;
      hold_d      = hold_q;
      pend_d      = pend_q;
      rise_done_d = 1'b0;
      fall_done_d = 1'b0;
      drop_opp    = 1'b0;
      if (accept) begin
         level_d     = ~level_q;
         hold_d      = level_q ? LOW_LOAD : HIGH_LOAD;
         pend_d      = 1'b0;
         rise_done_d = ~level_q;
         fall_done_d = level_q;
      end else begin
         if (!hold_zero) hold_d = hold_q - 16'd1;
         if (cancel) begin
            pend_d = 1'b0;
         end else if (opp_req && !hold_zero) begin
            if (pend_q) drop_opp = 1'b1;
            else        pend_d   = 1'b1;
         end
      end
      dropped_d = (same_req & ~cancel) | drop_opp;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset_n) begin
         level_q     <= 1'b0;
         hold_q      <= 16'd0;
         pend_q      <= 1'b0;
         rise_done_q <= 1'b0;
         fall_done_q <= 1'b0;
         dropped_q   <= 1'b0;
      end else begin
         level_q     <= level_d;
         hold_q      <= hold_d;
         pend_q      <= pend_d;
         rise_done_q <= rise_done_d;
         fall_done_q <= fall_done_d;
         dropped_q   <= dropped_d;
      end
   end

   assign level_out = level_q;
   assign rise_done = rise_done_q;
   assign fall_done = fall_done_q;
   assign dropped   = dropped_q;
   assign busy      = (hold_q != 16'd0) | pend_q;

endmodule

// File: tb/tb_level_from_edges.sv
// Scoreboard bench for level_from_edges: directed per-cycle expectations
// plus a random round-trip through an edge detector on level_out.
module tb_level_from_edges;

   logic clk = 1'b0;
   logic reset_n;
   logic rise_req;
   logic fall_req;

   logic s_level, s_rise_done, s_fall_done, s_dropped, s_busy;
   logic f_level, f_rise_done, f_fall_done, f_dropped, f_busy;

   int checks = 0;
   int errors = 0;

   logic [4:0] exp_q [$];
   logic       edge_q [$];

   localparam int SLOW_HIGH = 4;
   localparam int SLOW_LOW  = 3;

   always #5 clk = ~clk;

   level_from_edges #(.MIN_HIGH(SLOW_HIGH), .MIN_LOW(SLOW_LOW)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rise_req  (rise_req),
      .fall_req  (fall_req),
      .level_out (s_level),
      .rise_done (s_rise_done),
      .fall_done (s_fall_done),
      .dropped   (s_dropped),
      .busy      (s_busy)
   );

   level_from_edges #(.MIN_HIGH(1), .MIN_LOW(1)) u_fast (
      .clk       (clk),
      .reset_n   (reset_n),
      .rise_req  (rise_req),
      .fall_req  (fall_req),
      .level_out (f_level),
      .rise_done (f_rise_done),
      .fall_done (f_fall_done),
      .dropped   (f_dropped),
      .busy      (f_busy)
   );

   // Observation order: {level, rise_done, fall_done, dropped, busy}
   logic [4:0] slow_obs, fast_obs;
   assign slow_obs = {s_level, s_rise_done, s_fall_done, s_dropped, s_busy};
   assign fast_obs = {f_level, f_rise_done, f_fall_done, f_dropped, f_busy};

   // Stimulus word {reset_n, rise_req, fall_req}; outputs sampled 1ns after the edge.
   task automatic drive_cycle(input logic [2:0] s);
      reset_n  = s[2];
      rise_req = s[1];
      fall_req = s[0];
      @(posedge clk);
      #1;
      rise_req = 1'b0;
      fall_req = 1'b0;
   endtask

   task automatic do_reset();
      drive_cycle(3'b000);
      drive_cycle(3'b000);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [2:0] stim [5];
      logic [4:0] exp_v [5];
      logic [4:0] want;
      stim  = '{3'b010, 3'b010, 3'b010, 3'b110, 3'b100};
      exp_v = '{5'b00000, 5'b00000, 5'b00000, 5'b11001, 5'b10001};
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(exp_v[i]);
         drive_cycle(stim[i]);
         want = exp_q.pop_front();
         checks++;
         if (slow_obs !== want) begin
            errors++;
            $display("FAIL reset[%0d] got %b want %b", i, slow_obs, want);
         end
      end
   endtask

   task automatic test_pended_fall();
      logic [2:0] stim [10];
      logic [4:0] exp_v [10];
      logic [4:0] want;
      stim  = '{3'b110, 3'b100, 3'b101, 3'b100, 3'b100,
                3'b100, 3'b110, 3'b100, 3'b100, 3'b100};
      exp_v = '{5'b11001, 5'b10001, 5'b10001, 5'b10001, 5'b00101,
                5'b00001, 5'b00001, 5'b11001, 5'b10001, 5'b10001};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(exp_v[i]);
         drive_cycle(stim[i]);
         want = exp_q.pop_front();
         checks++;
         if (slow_obs !== want) begin
            errors++;
            $display("FAIL pended_fall[%0d] got %b want %b", i, slow_obs, want);
         end
      end
   endtask

   task automatic test_redundant();
      logic [2:0] stim [2];
      logic [4:0] exp_v [2];
      logic [4:0] want;
      stim  = '{3'b101, 3'b100};
      exp_v = '{5'b00010, 5'b00000};
      do_reset();
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(exp_v[i]);
         drive_cycle(stim[i]);
         want = exp_q.pop_front();
         checks++;
         if (slow_obs !== want) begin
            errors++;
            $display("FAIL redundant[%0d] got %b want %b", i, slow_obs, want);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [2:0] stim [3];
      logic [4:0] exp_v [3];
      logic [4:0] want;
      // Second pair arrives while high with hold running and nothing pending.
      stim  = '{3'b111, 3'b111, 3'b100};
      exp_v = '{5'b11011, 5'b10011, 5'b10001};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(exp_v[i]);
         drive_cycle(stim[i]);
         want = exp_q.pop_front();
         checks++;
         if (slow_obs !== want) begin
            errors++;
            $display("FAIL simultaneous[%0d] got %b want %b", i, slow_obs, want);
         end
      end
   endtask

   task automatic test_cancel();
      logic [2:0] stim [7];
      logic [4:0] exp_v [7];
      logic [4:0] want;
      stim  = '{3'b110, 3'b101, 3'b101, 3'b110, 3'b100, 3'b100, 3'b100};
      exp_v = '{5'b11001, 5'b10001, 5'b10011, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(exp_v[i]);
         drive_cycle(stim[i]);
         want = exp_q.pop_front();
         checks++;
         if (slow_obs !== want) begin
            errors++;
            $display("FAIL cancel[%0d] got %b want %b", i, slow_obs, want);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      logic [2:0] stim [5];
      logic [4:0] exp_v [5];
      logic [4:0] want;
      stim  = '{3'b110, 3'b101, 3'b001, 3'b100, 3'b110};
      exp_v = '{5'b11001, 5'b10001, 5'b00000, 5'b00000, 5'b11001};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(exp_v[i]);
         drive_cycle(stim[i]);
         want = exp_q.pop_front();
         checks++;
         if (slow_obs !== want) begin
            errors++;
            $display("FAIL reset_mid_hold[%0d] got %b want %b", i, slow_obs, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] stim [5];
      logic [4:0] exp_v [5];
      logic [4:0] want;
      stim  = '{3'b110, 3'b101, 3'b110, 3'b101, 3'b100};
      exp_v = '{5'b11000, 5'b00100, 5'b11000, 5'b00100, 5'b00000};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(exp_v[i]);
         drive_cycle(stim[i]);
         want = exp_q.pop_front();
         checks++;
         if (fast_obs !== want) begin
            errors++;
            $display("FAIL back_to_back[%0d] got %b want %b", i, fast_obs, want);
         end
      end
   endtask

   task automatic test_round_trip();
      logic prev_level;
      logic want_rise;
      bit   first;
      int   run;
      int   n_edges;
      int   min_run;
      do_reset();
      prev_level = 1'b0;
      first      = 1'b1;
      run        = 0;
      n_edges    = 0;
      for (int i = 0; i < 3000; i++) begin
         drive_cycle({1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
         if (s_level !== prev_level) begin
            min_run = prev_level ? SLOW_HIGH : SLOW_LOW;
            if (!first) begin
               checks++;
               if (run < min_run) begin
                  errors++;
                  $display("FAIL hold_window cycle %0d got %0d want >=%0d", i, run, min_run);
               end
            end
            first = 1'b0;
            edge_q.push_back(s_level);
            n_edges++;
            run = 1;
         end else begin
            run++;
         end
         prev_level = s_level;
         if (s_rise_done || s_fall_done) begin
            checks++;
            if (edge_q.size() == 0) begin
               errors++;
               $display("FAIL round_trip cycle %0d got done pulse want no pulse", i);
            end else begin
               want_rise = edge_q.pop_front();
               if ({s_rise_done, s_fall_done} !== {want_rise, ~want_rise}) begin
                  errors++;
                  $display("FAIL round_trip cycle %0d got %b want %b", i,
                           {s_rise_done, s_fall_done}, {want_rise, ~want_rise});
               end
            end
         end
      end
      checks++;
      if (edge_q.size() != 0 || n_edges < 10) begin
         errors++;
         $display("FAIL round_trip_count got %0d unmatched of %0d edges want 0 unmatched, >=10 edges",
                  edge_q.size(), n_edges);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      rise_req = 1'b0;
      fall_req = 1'b0;
      test_reset();
      test_pended_fall();
      test_redundant();
      test_simultaneous();
      test_cancel();
      test_reset_mid_hold();
      test_back_to_back();
      test_round_trip();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/level_from_edges.md
# level_from_edges

Edge-to-level encoder for the watch datapath. It converts single-cycle rise/fall request strobes into a clean level waveform with enforced minimum high and low times. It is the transmit-side counterpart of the edge detectors used on button and tick lines: feeding `level_out` through an edge detector regenerates the accepted requests. It drives buzzer/LED enables and synthetic test stimulus for downstream edge-detected inputs.

## Interface
- `MIN_HIGH`, default 4: minimum cycles `level_out` stays 1 after a rise; legal range 1..65535.
- `MIN_LOW`, default 4: minimum cycles `level_out` stays 0 after a fall; legal range 1..65535.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `rise_req` input 1: one-cycle strobe requesting level 0→1.
- `fall_req` input 1: one-cycle strobe requesting level 1→0.
- `level_out` output 1: registered level waveform.
- `rise_done` output 1: registered one-cycle pulse, coincident with the first cycle `level_out`=1.
- `fall_done` output 1: registered one-cycle pulse, coincident with the first cycle `level_out`=0.
- `dropped` output 1: registered one-cycle pulse, asserted the cycle after a request is discarded.
- `busy` output 1: 1 while the hold counter is nonzero or a request is pending.

## Operation
- **State:**
  - `level` (drives `level_out`).
  - `hold_cnt`, 16 bits.
  - `pend_valid`, a one-deep pending-transition flag. A pending transition is always toward the opposite of the current level.
- **Effective request** this cycle is the new opposite-level strobe if present, else the pending transition.
- **Acceptance:** when `hold_cnt`==0 and an effective request exists:
  - Toggle `level`.
  - Load `hold_cnt` with `MIN_HIGH`-1 (rise) or `MIN_LOW`-1 (fall).
  - Clear `pend_valid`.
  - Pulse `rise_done`/`fall_done` in the next cycle.
- **Hold:** while `hold_cnt`!=0, decrement by 1 per cycle, saturating at 0.
  - An opposite-level strobe with no pending sets `pend_valid`.
  - An opposite-level strobe with pending already set is dropped.
- **Same-level strobe** (`rise_req` while high, `fall_req` while low):
  - With pending set: cancels the pending transition. No drop, no level change.
  - With no pending: dropped.
- **Simultaneous `rise_req` and `fall_req`:**
  - The opposite-level strobe is processed per the rules above.
  - The same-level strobe is dropped, and never cancels in that cycle.
  - `dropped` is a single pulse even if both rules fire.
- **Reset (`reset_n`=0 at a clock edge), including mid-hold or with pending:**
  - `level_out`=0, `hold_cnt`=0, `pend_valid`=0.
  - `rise_done`=`fall_done`=`dropped`=0, `busy`=0.
  - Strobes during reset are ignored and not recorded.
  - A rise is accepted immediately on the first cycle after reset release; the low hold counts as already satisfied.
- **Wrap-around:** none. `hold_cnt` never underflows; both parameters are clamped to a minimum of 1 at elaboration.

## Timing
- **Latency:** strobe sampled at edge N with `hold_cnt`==0 → `level_out` and done pulse change after edge N, visible in cycle N+1.
- **Hold windows:**
  - After a rise, `level_out` is 1 for at least `MIN_HIGH` cycles.
  - After a fall, `level_out` is 0 for at least `MIN_LOW` cycles.
  - A pending request is accepted in the cycle `hold_cnt` reads 0. The level therefore changes exactly `MIN_HIGH`/`MIN_LOW` cycles after the previous transition.
- **Maximum toggle rate** with `MIN_HIGH`=`MIN_LOW`=1: one transition per cycle.
- **Outputs:** all registered; no combinational path from inputs to outputs.
- **`busy`:** reflects state after the current edge. It goes 0 in the cycle `hold_cnt`=0 and `pend_valid`=0.

## Test plan
- **Reset:** `reset_n`=0 for 3 cycles with `rise_req`=1 throughout → `level_out`=0, `busy`=0, no pulses. Release and strobe `rise_req` at cycle 0 → `level_out`=1 and `rise_done`=1 at cycle 1.
- **Pended fall** (`MIN_HIGH`=4, `MIN_LOW`=3):
  - `rise_req` at cycle 0 and `fall_req` at cycle 2 → `level_out`=1 in cycles 1–4 and `busy`=1 in cycles 1–4.
  - `level_out`=0 and `fall_done` at cycle 5.
  - `rise_req` at cycle 6 → `level_out` rises at cycle 8.
- **Redundant strobe:** `fall_req` while low and idle → `dropped`=1 for one cycle, `level_out` unchanged, `busy`=0.
- **Simultaneous strobes:** `rise_req` and `fall_req` together while low and idle → `level_out`=1 and `rise_done` next cycle, `dropped`=1 same cycle.
- **Cancel:** high with `fall_req` pending, then `rise_req` before expiry → `pend_valid` cleared, `level_out` stays 1 past `MIN_HIGH`, no `fall_done`, no `dropped`. A second `fall_req` while pending → `dropped`.
- **Reset mid-hold, plus round-trip:**
  - Reset with level high and a fall pending → `level_out`=0 next cycle, no `fall_done`.
  - Random strobe stream with `level_out` fed to an edge detector → detector edges match the `rise_done`/`fall_done` count and order exactly.
